// File: rtl/hm01b0_pattern_gen.sv
// HM01B0-style camera transmitter: divided pixel clock plus hsync/vsync/pixdata
// framing with selectable test patterns, all in the system clock domain.
module hm01b0_pattern_gen #(
    parameter int H_ACTIVE = 320,
    parameter int V_ACTIVE = 240,
    parameter int H_BLANK  = 16,
    parameter int V_LEAD   = 4,
    parameter int V_BLANK  = 64,
    parameter int CLK_DIV  = 4
) (
    input  logic       clock,
    input  logic       nreset,
    input  logic       enable,
    input  logic [1:0] pattern_sel,
    output logic       pixclk,
    output logic [7:0] pixdata,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_done
);
    localparam int CW     = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int RW     = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int DW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BMAX_A = (H_BLANK > V_LEAD) ? H_BLANK : V_LEAD;
    localparam int BMAX   = (BMAX_A > V_BLANK) ? BMAX_A : V_BLANK;
    localparam int BW     = $clog2(BMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VLEAD,
        S_LINE,
        S_HBLANK,
        S_VBLANK
    } state_t;

    state_t        r_state;
    logic [DW-1:0] r_div;
    logic          r_pixclk;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [BW-1:0] r_cnt;
    logic [7:0]    r_frame;
    logic [1:0]    r_sel;
    logic [7:0]    r_pixdata;
    logic          r_hsync;
    logic          r_vsync;
    logic          r_frame_done;

    logic          w_tick;
    logic [CW-1:0] w_col_inc;
    logic [RW-1:0] w_row_inc;

    function automatic logic [7:0] pattern(input logic [1:0]  sel,
                                           input logic [15:0] col,
                                           input logic [15:0] row,
                                           input logic [7:0]  frame);
        logic [7:0] v;
        case (sel)
            2'd0:    v = col[7:0];
            2'd1:    v = row[7:0];
            2'd2:    v = (col[3] ^ row[3]) ? 8'hFF : 8'h00;
            default: v = col[7:0] + row[7:0] + frame;
        endcase
        return v;
    endfunction

    // A tick is the edge on which pixclk falls, so everything launched here is
    // stable across the following rising edge where the receiver samples.
    assign w_tick    = r_pixclk && (r_div == DW'(CLK_DIV - 1));
    assign w_col_inc = r_col + CW'(1);
    assign w_row_inc = r_row + RW'(1);

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_state      <= S_IDLE;
            r_div        <= '0;
            r_pixclk     <= 1'b0;
            r_col        <= '0;
            r_row        <= '0;
            r_cnt        <= '0;
            r_frame      <= '0;
            r_sel        <= '0;
            r_pixdata    <= '0;
            r_hsync      <= 1'b0;
            r_vsync      <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (r_div == DW'(CLK_DIV - 1)) begin
                r_div    <= '0;
                r_pixclk <= ~r_pixclk;
            end else begin
                r_div <= r_div + DW'(1);
            end

            if (w_tick) begin
                case (r_state)
                    S_IDLE: begin
                        if (enable) begin
                            r_sel   <= pattern_sel;
                            r_row   <= '0;
                            r_cnt   <= '0;
                            r_vsync <= 1'b1;
                            r_state <= S_VLEAD;
                        end
                    end
                    S_VLEAD: begin
                        if (r_cnt == BW'(V_LEAD - 1)) begin
                            r_hsync   <= 1'b1;
                            r_col     <= '0;
                            r_pixdata <= pattern(r_sel, 16'd0, 16'(r_row), r_frame);
                            r_state   <= S_LINE;
                        end else begin
                            r_cnt <= r_cnt + BW'(1);
                        end
                    end
                    S_LINE: begin
                        if (r_col == CW'(H_ACTIVE - 1)) begin
                            r_hsync   <= 1'b0;
                            r_pixdata <= '0;
                            r_cnt     <= '0;
                            r_state   <= S_HBLANK;
                        end else begin
                            r_col     <= w_col_inc;
                            r_pixdata <= pattern(r_sel, 16'(w_col_inc), 16'(r_row), r_frame);
                        end
                    end
                    S_HBLANK: begin
                        if (r_cnt == BW'(H_BLANK - 1)) begin
                            r_cnt <= '0;
                            if (r_row == RW'(V_ACTIVE - 1)) begin
                                r_vsync      <= 1'b0;
                                r_frame_done <= 1'b1;
                                r_state      <= S_VBLANK;
                            end else begin
                                r_row     <= w_row_inc;
                                r_col     <= '0;
                                r_hsync   <= 1'b1;
                                r_pixdata <= pattern(r_sel, 16'd0, 16'(w_row_inc), r_frame);
                                r_state   <= S_LINE;
                            end
                        end else begin
                            r_cnt <= r_cnt + BW'(1);
                        end
                    end
                    S_VBLANK: begin
                        // The last blanking tick doubles as the IDLE check so back-to-back
                        // frames keep vsync low for exactly V_BLANK pixel periods.
                        if (r_cnt == BW'(V_BLANK - 1)) begin
                            r_frame <= r_frame + 8'd1;
                            r_cnt   <= '0;
                            if (enable) begin
                                r_sel   <= pattern_sel;
                                r_row   <= '0;
                                r_vsync <= 1'b1;
                                r_state <= S_VLEAD;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_cnt <= r_cnt + BW'(1);
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign pixclk     = r_pixclk;
    assign pixdata    = r_pixdata;
    assign hsync      = r_hsync;
    assign vsync      = r_vsync;
    assign frame_done = r_frame_done;

endmodule
